// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: request opcodes,
// FSM state encoding and word-addressing constants.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LW   = 2'd1,
    OP_SW   = 2'd2
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = $clog2(WORD_BYTES);

  // Byte address not on a word boundary.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[ADDR_LSB-1:0] != '0;
  endfunction

  // Only loads and stores start a transaction; every other encoding is ignored.
  function automatic logic is_mem_op(input lsu_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_mem.sv
// Synchronous single-port word memory with registered read data. Read data
// only changes on a read access, so it holds between loads.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; contents survive rst_n and power
  // up undefined, and a reset here would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem_q[idx];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one LW/SW at a time, spends MEM_LATENCY cycles in
// ACCESS, then pulses a one-cycle response. Bad addresses skip the access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  lsu_op_e           req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  lsu_op_e           op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_sel_q;

  logic              accept;
  logic              out_of_range;
  logic              req_err;
  logic              access_done;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready    = (state_q == IDLE);
  assign stall        = (state_q != IDLE);
  assign resp_valid   = (state_q == RESP);
  assign accept       = req_valid && req_ready && is_mem_op(req_op);
  assign out_of_range = req_addr[DATA_W-1:ADDR_LSB+IDX_W] != '0;
  assign req_err      = is_misaligned(req_addr) || out_of_range;
  assign access_done  = (state_q == ACCESS) && (cnt_q == '0);

  // NOTE: state_d gets its hold value before the case, so no path through
  // this block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request is latched at acceptance; the bus is free to change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NONE;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      idx_q   <= req_addr[ADDR_LSB +: IDX_W];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && !req_err) begin
      cnt_q <= LAT_LOAD;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Response qualifiers change only on the edge that enters RESP, so
  // resp_err and resp_rdata hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else if (accept && req_err) begin
      err_q    <= 1'b1;
      rd_sel_q <= 1'b0;
    end else if (access_done) begin
      err_q    <= 1'b0;
      rd_sel_q <= (op_q == OP_LW);
    end
  end

  assign resp_err   = err_q;
  assign resp_rdata = rd_sel_q ? mem_rdata : '0;

  lsu_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (access_done),
    .we    (op_q == OP_SW),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  a_resp_pulse: assert property (
    @(posedge clk) disable iff (!rst_n) resp_valid |=> !resp_valid);
  a_no_accept_busy: assert property (
    @(posedge clk) disable iff (!rst_n) stall |-> !req_ready);

endmodule
